// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM; Moore outputs decoded from state (FETCH strobes qualified by mem_ready).
// Latency: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4; mem_ready=0 stalls FETCH, MEMRD and MEMWR.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       BranchNe,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:       state_d = S_EXEC;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_ADDIEX;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    BranchNe    = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC and IR only advance once the instruction word has arrived
        PCWrite = mem_ready;
        IRWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI});
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemToReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNe    = (opcode == OP_BNE);
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table, hand-written stall/reset sequences,
// then random instruction streams checked against an instruction-level state-sequence model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA, BranchNe;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  int passed = 0;
  int total  = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .BranchNe(BranchNe), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  logic [18:0] dut_ctl;
  assign dut_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
                    RegWrite, ALUSrcA, BranchNe, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};
  endfunction

  // Expected control word for a state, straight from the per-state output list
  function automatic logic [18:0] exp_ctl(input int st, input logic [5:0] op, input logic mr);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mw = 0, irw = 0, m2r = 0, rd = 0;
    logic rw = 0, sa = 0, bne = 0, done = 0, ill = 0;
    logic [1:0] sb = 0, ao = 0, ps = 0;
    case (st)
      1:  begin mrd = 1; sb = 2'b01; pcw = mr; irw = mr; end
      2:  begin sb = 2'b11; ill = !legal(op); end
      3:  begin sa = 1; sb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin m2r = 1; rw = 1; done = 1; end
      6:  begin mw = 1; iord = 1; done = mr; end
      7:  begin sa = 1; ao = 2'b10; end
      8:  begin rd = 1; rw = 1; done = 1; end
      9:  begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; bne = (op == 6'h05); done = 1; end
      10: begin pcw = 1; ps = 2'b10; done = 1; end
      11: begin sa = 1; sb = 2'b10; end
      12: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mw, irw, m2r, rd, rw, sa, bne, sb, ao, ps, done, ill};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic mr);
    @(negedge clk);
    rst_n = r; opcode = op; mem_ready = mr;
    #1;
  endtask

  task automatic chk_cyc(input string nm, input int st);
    check({nm, " state"}, {28'd0, state}, st);
    check({nm, " ctl"}, {13'd0, dut_ctl}, {13'd0, exp_ctl(st, opcode, mem_ready)});
  endtask

  typedef struct { logic r; logic [5:0] op; logic mr; int st; } vec_t;
  typedef struct { int st; logic mr; } cyc_t;

  vec_t vt[22];
  cyc_t q[$];

  initial begin
    rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // rows: inputs driven this cycle, state expected this cycle
    vt[0]  = '{1'b1, 6'h00, 1'b1, 0};
    vt[1]  = '{1'b1, 6'h00, 1'b1, 1};
    vt[2]  = '{1'b1, 6'h00, 1'b1, 2};
    vt[3]  = '{1'b1, 6'h00, 1'b1, 7};
    vt[4]  = '{1'b1, 6'h00, 1'b1, 8};
    vt[5]  = '{1'b1, 6'h05, 1'b0, 1};
    vt[6]  = '{1'b1, 6'h05, 1'b0, 1};
    vt[7]  = '{1'b1, 6'h05, 1'b1, 1};
    vt[8]  = '{1'b1, 6'h05, 1'b1, 2};
    vt[9]  = '{1'b1, 6'h05, 1'b0, 9};
    vt[10] = '{1'b1, 6'h04, 1'b1, 1};
    vt[11] = '{1'b1, 6'h04, 1'b1, 2};
    vt[12] = '{1'b1, 6'h04, 1'b1, 9};
    vt[13] = '{1'b1, 6'h3F, 1'b1, 1};
    vt[14] = '{1'b1, 6'h3F, 1'b1, 2};
    vt[15] = '{1'b1, 6'h2B, 1'b1, 1};
    vt[16] = '{1'b1, 6'h2B, 1'b1, 2};
    vt[17] = '{1'b1, 6'h2B, 1'b0, 3};
    vt[18] = '{1'b1, 6'h2B, 1'b0, 6};
    vt[19] = '{1'b0, 6'h2B, 1'b0, 6};
    vt[20] = '{1'b1, 6'h2B, 1'b0, 0};
    vt[21] = '{1'b1, 6'h2B, 1'b0, 1};
    for (int i = 0; i < 22; i++) begin
      step(vt[i].r, vt[i].op, vt[i].mr);
      chk_cyc($sformatf("vec%0d", i), vt[i].st);
    end

    // lw with a three-cycle stall in MEMRD
    step(1, 6'h23, 1); chk_cyc("lw fetch", 1);
    step(1, 6'h23, 1); chk_cyc("lw decode", 2);
    step(1, 6'h23, 0); chk_cyc("lw memadr", 3);
    for (int k = 0; k < 3; k++) begin
      step(1, 6'h23, 0); chk_cyc($sformatf("lw memrd stall%0d", k), 4);
    end
    step(1, 6'h23, 1); chk_cyc("lw memrd ready", 4);
    step(1, 6'h23, 0); chk_cyc("lw memwb", 5);
    // reset in the middle of a FETCH stall
    step(1, 6'h00, 0); chk_cyc("fetch stall", 1);
    step(0, 6'h00, 0); chk_cyc("fetch stall rst", 1);
    step(1, 6'h00, 0); chk_cyc("post rst idle", 0);

    // random instruction stream; model is a per-instruction list of expected states
    begin
      logic [5:0] ops[7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};
      int done_seen, n_legal;
      logic [5:0] op;
      cyc_t c;
      n_legal = 0;
      for (int n = 0; n < 150; n++) begin
        int sel = $urandom_range(0, 7);
        if (sel < 7) op = ops[sel];
        else begin
          op = 6'($urandom_range(0, 63));
          while (legal(op)) op = 6'($urandom_range(0, 63));
        end
        q.delete();
        repeat ($urandom_range(0, 3)) q.push_back('{1, 1'b0});
        q.push_back('{1, 1'b1});
        q.push_back('{2, 1'($urandom_range(0, 1))});
        case (op)
          6'h00: begin q.push_back('{7, 1'($urandom_range(0, 1))}); q.push_back('{8, 1'($urandom_range(0, 1))}); end
          6'h23: begin
            q.push_back('{3, 1'($urandom_range(0, 1))});
            repeat ($urandom_range(0, 3)) q.push_back('{4, 1'b0});
            q.push_back('{4, 1'b1});
            q.push_back('{5, 1'($urandom_range(0, 1))});
          end
          6'h2B: begin
            q.push_back('{3, 1'($urandom_range(0, 1))});
            repeat ($urandom_range(0, 3)) q.push_back('{6, 1'b0});
            q.push_back('{6, 1'b1});
          end
          6'h04, 6'h05: q.push_back('{9, 1'($urandom_range(0, 1))});
          6'h02: q.push_back('{10, 1'($urandom_range(0, 1))});
          6'h08: begin q.push_back('{11, 1'($urandom_range(0, 1))}); q.push_back('{12, 1'($urandom_range(0, 1))}); end
          default: ;
        endcase
        if (legal(op)) n_legal++;
        done_seen = 0;
        while (q.size() > 0) begin
          c = q.pop_front();
          step(1, op, c.mr);
          chk_cyc($sformatf("rnd%0d op%0h", n, op), c.st);
          if (instr_done) done_seen++;
        end
        check($sformatf("rnd%0d done count", n), done_seen, legal(op) ? 1 : 0);
      end
      step(1, 6'h00, 1);
      chk_cyc("rnd end fetch", 1);
      check("legal instr count nonzero", 32'(n_legal > 0), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port opcode, input, 6, instruction[31:26] from the instruction register, stable from DECODE onward.
REQ-004 SHALL have port mem_ready, input, 1, memory access complete this cycle.
REQ-005 SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, BranchNe as outputs, 1 bit each: datapath control lines.
REQ-006 SHALL have ports ALUSrcB, ALUOp, PCSource as outputs, 2 bits each: ALUOp feeds the existing ALUOp-to-ALUControl decoder unchanged.
REQ-007 SHALL have port state, output, 4, current FSM state for debug.
REQ-008 SHALL have port instr_done, output, 1, one-cycle pulse in the final state of each instruction.
REQ-009 SHALL have port illegal_op, output, 1, one-cycle pulse in DECODE on an unsupported opcode.

Function
REQ-010 SHALL be a Moore FSM: all control outputs are decoded from state only, except the mem_ready qualification of PCWrite and IRWrite in FETCH (REQ-015).
REQ-011 SHALL use state encoding IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12; codes 13-15 SHALL go to IDLE on the next clock.
REQ-012 SHALL drive 0 on every output not listed for the current state.
REQ-013 IDLE: all outputs 0; transition SHALL be to FETCH on the next clock.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
REQ-015 FETCH: IRWrite and PCWrite SHALL equal mem_ready; the FSM SHALL hold in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-017 DECODE next state by opcode: 0x00 -> EXEC; 0x23 or 0x2B -> MEMADR; 0x04 or 0x05 -> BRANCH; 0x02 -> JUMP; 0x08 -> ADDIEX; any other -> FETCH with illegal_op=1 for that cycle.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEMRD if opcode=0x23, else MEMWR.
REQ-019 MEMRD: MemRead=1, IorD=1; SHALL hold while mem_ready=0 and go to MEMWB when mem_ready=1.
REQ-020 MEMWB: RegDst=0, MemToReg=1, RegWrite=1, instr_done=1; next state FETCH.
REQ-021 MEMWR: MemWrite=1, IorD=1; SHALL hold while mem_ready=0; when mem_ready=1, instr_done=1 and next state FETCH.
REQ-022 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-023 ALUWB: RegDst=1, MemToReg=0, RegWrite=1, instr_done=1; next state FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNe=1 if opcode=0x05 else 0, instr_done=1; next state FETCH.
REQ-025 JUMP: PCWrite=1, PCSource=10, instr_done=1; next state FETCH.
REQ-026 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state ADDIWB.
REQ-027 ADDIWB: RegDst=0, MemToReg=0, RegWrite=1, instr_done=1; next state FETCH.
REQ-028 Latency without stalls SHALL be: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4 cycles, counted from FETCH entry to FETCH re-entry.
REQ-029 mem_ready SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.

Reset
REQ-030 When rst_n=0 at a rising clk edge, state SHALL become IDLE regardless of current state, including mid-stall in FETCH, MEMRD or MEMWR.
REQ-031 While in IDLE, every output SHALL be 0, with state=0.
REQ-032 No write strobe (MemWrite, RegWrite, PCWrite, PCWriteCond, IRWrite) SHALL assert in the cycle after a reset edge.

Verification
REQ-033 Reset release, mem_ready=1, opcode=0x00 -> states 0,1,2,7,8,1; RegWrite=1 and RegDst=1 only in state 8; instr_done high exactly one cycle.
REQ-034 opcode=0x23, mem_ready low for 3 cycles in MEMRD -> state 4 held 4 cycles with MemRead=1 and IorD=1; then state 5 with MemToReg=1 and RegWrite=1.
REQ-035 opcode=0x05 -> BRANCH with PCWriteCond=1, BranchNe=1, ALUOp=01, PCSource=01; repeat with 0x04 -> BranchNe=0.
REQ-036 FETCH with mem_ready=0 for 2 cycles -> IRWrite=0 and PCWrite=0 in both; mem_ready=1 -> both 1 for one cycle, then DECODE.
REQ-037 opcode=0x3F -> illegal_op pulses one cycle in DECODE; next state FETCH; no write strobe asserted.
REQ-038 rst_n=0 during MEMWR stall -> next state IDLE, MemWrite=0 that cycle; after release, FETCH follows one cycle later.
